// File: rtl/edu_tpu_wb_mem_if.sv
// Caravel Wishbone slave bus plus the operand stream port to the array.
// The slave modport is the memory side; master is the bus/array side.
interface edu_tpu_wb_mem_if;
  logic        caravel_wb_stb_i;
  logic        caravel_wb_cyc_i;
  logic        caravel_wb_we_i;
  logic [3:0]  caravel_wb_sel_i;
  logic [31:0] caravel_wb_dat_i;
  logic [31:0] caravel_wb_adr_i;
  logic        caravel_wb_ack_o;
  logic [31:0] caravel_wb_dat_o;
  logic [31:0] stream_data_o;
  logic        stream_valid_o;
  logic        stream_ready_i;
  logic        stream_last_o;

  modport slave (
    input  caravel_wb_stb_i,
    input  caravel_wb_cyc_i,
    input  caravel_wb_we_i,
    input  caravel_wb_sel_i,
    input  caravel_wb_dat_i,
    input  caravel_wb_adr_i,
    output caravel_wb_ack_o,
    output caravel_wb_dat_o,
    output stream_data_o,
    output stream_valid_o,
    input  stream_ready_i,
    output stream_last_o
  );

  modport master (
    output caravel_wb_stb_i,
    output caravel_wb_cyc_i,
    output caravel_wb_we_i,
    output caravel_wb_sel_i,
    output caravel_wb_dat_i,
    output caravel_wb_adr_i,
    input  caravel_wb_ack_o,
    input  caravel_wb_dat_o,
    input  stream_data_o,
    input  stream_valid_o,
    output stream_ready_i,
    input  stream_last_o
  );
endinterface

// File: rtl/edu_tpu_wb_mem.sv
// TPU operand RAM behind a Caravel Wishbone slave, with a
// stream engine that replays a RAM window to the systolic array.
module edu_tpu_wb_mem #(
  parameter logic [19:0] BASE_ADDRESS = 20'h3000_0,
  parameter int          ADDR_W       = 8,
  parameter int          WAIT_STATES  = 0
) (
  input  logic                   caravel_wb_clk_i,
  input  logic                   caravel_wb_rst_i,
  edu_tpu_wb_mem_if.slave        bus
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [1:0] WS    = 2'(WAIT_STATES);
  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_HOLD
  } state_t;

  logic              w_clk;
  logic              w_rst;
  logic              w_cyc;
  logic              w_stb;
  logic              w_we;
  logic [3:0]        w_sel;
  logic [31:0]       w_wdat;
  logic [31:0]       w_adr;
  logic              w_rdy;

  assign w_clk  = caravel_wb_clk_i;
  assign w_rst  = caravel_wb_rst_i;
  assign w_cyc  = bus.caravel_wb_cyc_i;
  assign w_stb  = bus.caravel_wb_stb_i;
  assign w_we   = bus.caravel_wb_we_i;
  assign w_sel  = bus.caravel_wb_sel_i;
  assign w_wdat = bus.caravel_wb_dat_i;
  assign w_adr  = bus.caravel_wb_adr_i;
  assign w_rdy  = bus.stream_ready_i;

  logic w_unused;
  assign w_unused = &{1'b0, w_adr};

  logic w_hit;
  logic w_ram_sel;
  logic w_reg_sel;
  assign w_hit     = w_cyc & w_stb
                   & (w_adr[31:12] == BASE_ADDRESS);
  assign w_ram_sel = w_hit & ~w_adr[11];
  assign w_reg_sel = w_hit &  w_adr[11];

  logic [31:0] w_mask;
  assign w_mask = {{8{w_sel[3]}}, {8{w_sel[2]}},
                   {8{w_sel[1]}}, {8{w_sel[0]}}};

  logic        r_ack;
  logic        r_act;
  logic [1:0]  r_cnt;
  logic        r_ack_ram;
  logic [31:0] r_reg_q;
  logic [31:0] r_ram_q;
  logic        w_fire;
  logic        w_wr;

  // A hit seen in the ACK cycle is ignored so the next access
  // starts cleanly on the following cycle.
  always_comb begin
    w_fire = 1'b0;
    if (w_hit && !r_ack) begin
      if (r_act) w_fire = (r_cnt == WS);
      else       w_fire = (WS == 2'd0);
    end
  end

  assign w_wr = w_fire & w_we;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_ack     <= 1'b0;
      r_act     <= 1'b0;
      r_cnt     <= 2'd0;
      r_ack_ram <= 1'b0;
    end else if (!w_hit || r_ack) begin
      r_ack <= 1'b0;
      r_act <= 1'b0;
      r_cnt <= 2'd0;
    end else if (w_fire) begin
      r_ack     <= 1'b1;
      r_act     <= 1'b0;
      r_cnt     <= 2'd0;
      r_ack_ram <= ~w_adr[11];
    end else if (!r_act) begin
      r_act <= 1'b1;
      r_cnt <= 2'd1;
    end else begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  state_t          r_state;
  state_t          w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_rem;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_sdat;
  logic              r_svld;
  logic              r_slast;

  logic w_start;
  logic w_len_zero;
  assign w_start = w_wr & w_reg_sel
                 & (w_adr[3:2] == 2'd0)
                 & w_sel[0] & w_wdat[0];
  assign w_len_zero = (r_len == '0);

  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_fetch;
  logic              w_load;
  logic              w_accept;
  logic              w_go;
  logic              w_zero;

  assign w_ram_addr = w_ram_sel ? w_adr[ADDR_W+1:2] : r_ptr;

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge w_clk) begin
    if (w_wr && w_ram_sel)
      r_mem[w_ram_addr] <= (r_mem[w_ram_addr] & ~w_mask)
                         | (w_wdat & w_mask);
    if (w_ram_sel || w_fetch)
      r_ram_q <= r_mem[w_ram_addr];
  end

  logic [31:0] w_src_ext;
  logic [31:0] w_len_ext;
  logic [31:0] w_src_new;
  logic [31:0] w_len_new;
  logic [31:0] w_reg_rd;

  assign w_src_ext = {{(32-ADDR_W){1'b0}}, r_src};
  assign w_len_ext = {{(31-ADDR_W){1'b0}}, r_len};
  assign w_src_new = (w_src_ext & ~w_mask) | (w_wdat & w_mask);
  assign w_len_new = (w_len_ext & ~w_mask) | (w_wdat & w_mask);

  always_comb begin
    w_reg_rd = 32'd0;
    unique case (w_adr[3:2])
      2'd1:    w_reg_rd = {30'd0, r_done, r_busy};
      2'd2:    w_reg_rd = w_src_ext;
      2'd3:    w_reg_rd = w_len_ext;
      default: w_reg_rd = 32'd0;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_reg_q <= 32'd0;
      r_src   <= '0;
      r_len   <= '0;
    end else if (w_fire && w_reg_sel) begin
      r_reg_q <= w_reg_rd;
      if (w_we && w_adr[3:2] == 2'd2)
        r_src <= w_src_new[ADDR_W-1:0];
      if (w_we && w_adr[3:2] == 2'd3)
        r_len <= w_len_new[ADDR_W:0];
    end
  end

  assign bus.caravel_wb_ack_o = r_ack;
  assign bus.caravel_wb_dat_o = !r_ack    ? 32'd0
                              : r_ack_ram ? r_ram_q
                              :             r_reg_q;

  always_ff @(posedge w_clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start && !w_len_zero) w_next = S_FETCH;
      S_FETCH: if (!w_ram_sel) w_next = S_LOAD;
      S_LOAD:  w_next = S_HOLD;
      S_HOLD:  if (w_rdy)
                 w_next = (r_rem == REM_ONE) ? S_IDLE : S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_fetch  = (r_state == S_FETCH) & ~w_ram_sel;
    w_load   = (r_state == S_LOAD);
    w_accept = (r_state == S_HOLD) & w_rdy;
    w_go     = (r_state == S_IDLE) & w_start & ~w_len_zero;
    w_zero   = (r_state == S_IDLE) & w_start &  w_len_zero;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_ptr   <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sdat  <= 32'd0;
      r_svld  <= 1'b0;
      r_slast <= 1'b0;
    end else begin
      if (w_go) begin
        r_ptr  <= r_src;
        r_rem  <= r_len;
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end
      if (w_zero) r_done <= 1'b1;
      if (w_load) begin
        r_sdat  <= r_ram_q;
        r_svld  <= 1'b1;
        r_slast <= (r_rem == REM_ONE);
      end
      if (w_accept) begin
        r_svld  <= 1'b0;
        r_slast <= 1'b0;
        r_ptr   <= r_ptr + PTR_ONE;
        r_rem   <= r_rem - REM_ONE;
        if (r_rem == REM_ONE) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.stream_data_o  = r_sdat;
  assign bus.stream_valid_o = r_svld;
  assign bus.stream_last_o  = r_slast;

endmodule

// File: tb/tb_edu_tpu_wb_mem.sv
// Directed bench: three slaves on one shared Wishbone bus
// (WS=0 / WS=2 / ADDR_W=4), table vectors plus stream sequences.
module tb_edu_tpu_wb_mem;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic        rdy = 1'b0;
  logic        ack;
  logic [31:0] rdat;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] q0[$];

  always #5 clk = ~clk;

  edu_tpu_wb_mem_if bus0();
  edu_tpu_wb_mem_if bus2();
  edu_tpu_wb_mem_if bus4();

  assign bus0.caravel_wb_stb_i = stb;
  assign bus0.caravel_wb_cyc_i = cyc;
  assign bus0.caravel_wb_we_i  = we;
  assign bus0.caravel_wb_sel_i = sel;
  assign bus0.caravel_wb_dat_i = wdat;
  assign bus0.caravel_wb_adr_i = adr;
  assign bus0.stream_ready_i   = rdy;

  assign bus2.caravel_wb_stb_i = stb;
  assign bus2.caravel_wb_cyc_i = cyc;
  assign bus2.caravel_wb_we_i  = we;
  assign bus2.caravel_wb_sel_i = sel;
  assign bus2.caravel_wb_dat_i = wdat;
  assign bus2.caravel_wb_adr_i = adr;
  assign bus2.stream_ready_i   = rdy;

  assign bus4.caravel_wb_stb_i = stb;
  assign bus4.caravel_wb_cyc_i = cyc;
  assign bus4.caravel_wb_we_i  = we;
  assign bus4.caravel_wb_sel_i = sel;
  assign bus4.caravel_wb_dat_i = wdat;
  assign bus4.caravel_wb_adr_i = adr;
  assign bus4.stream_ready_i   = rdy;

  assign ack  = bus0.caravel_wb_ack_o | bus2.caravel_wb_ack_o
              | bus4.caravel_wb_ack_o;
  assign rdat = bus0.caravel_wb_dat_o | bus2.caravel_wb_dat_o
              | bus4.caravel_wb_dat_o;

  edu_tpu_wb_mem #(
    .BASE_ADDRESS(20'h3000_0), .ADDR_W(8), .WAIT_STATES(0)
  ) u0 (
    .caravel_wb_clk_i(clk), .caravel_wb_rst_i(rst), .bus(bus0)
  );

  edu_tpu_wb_mem #(
    .BASE_ADDRESS(20'h3000_2), .ADDR_W(8), .WAIT_STATES(2)
  ) u2 (
    .caravel_wb_clk_i(clk), .caravel_wb_rst_i(rst), .bus(bus2)
  );

  edu_tpu_wb_mem #(
    .BASE_ADDRESS(20'h3000_3), .ADDR_W(4), .WAIT_STATES(0)
  ) u4 (
    .caravel_wb_clk_i(clk), .caravel_wb_rst_i(rst), .bus(bus4)
  );

  always @(negedge clk)
    if (!rst && bus0.stream_valid_o && rdy)
      q0.push_back({bus0.stream_last_o, bus0.stream_data_o});

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wb(input logic [31:0] a, input logic w,
                    input logic [3:0] s, input logic [31:0] d,
                    output logic [31:0] rd, output int lat);
    @(negedge clk);
    adr = a; we = w; sel = s; wdat = d;
    cyc = 1'b1; stb = 1'b1;
    lat = 0; rd = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        rd = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (lat != 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    wb(a, 1'b1, 4'hF, d, rd, lat);
    chk($sformatf("wr_lat_%h", a), 32'(lat), 32'd1);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    wb(a, 1'b0, 4'hF, 32'h0, rd, lat);
    chk({nm, "_lat"}, 32'(lat), 32'd1);
    chk(nm, rd, exp);
  endtask

  task automatic wait_beats(input int base, input int n);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (q0.size() - base >= n) break;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic chk_beats(input string nm, input int base,
                           input int n, input logic [31:0] first);
    logic [32:0] b;
    chk({nm, "_count"}, 32'(q0.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      b = 33'h0;
      if (base + i < q0.size()) b = q0[base+i];
      chk($sformatf("%s_dat%0d", nm, i), b[31:0], first + 32'(i));
      chk($sformatf("%s_last%0d", nm, i), 32'(b[32]),
          32'(i == n - 1));
    end
  endtask

  vec_t        tv[19];
  logic [31:0] rd;
  int          lat;
  int          base;
  int          got;
  logic        ps;
  logic        pl;
  logic [31:0] pd;
  logic [32:0] b4[3];

  initial begin
    tv[0]  = '{32'h3000_0804, 1'b0, 4'hF, 32'h0, 32'h0, 1};
    tv[1]  = '{32'h3000_0010, 1'b1, 4'hF, 32'h0, 32'h0, 1};
    tv[2]  = '{32'h3000_0010, 1'b1, 4'h5, 32'hDEADBEEF, 32'h0, 1};
    tv[3]  = '{32'h3000_0010, 1'b0, 4'hF, 32'h0, 32'h00AD00EF, 1};
    tv[4]  = '{32'h3000_2010, 1'b1, 4'hF, 32'h0, 32'h0, 3};
    tv[5]  = '{32'h3000_2010, 1'b1, 4'h5, 32'hDEADBEEF, 32'h0, 3};
    tv[6]  = '{32'h3000_2010, 1'b0, 4'hF, 32'h0, 32'h00AD00EF, 3};
    tv[7]  = '{32'h3000_0010, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0, 1};
    tv[8]  = '{32'h3000_0010, 1'b0, 4'hF, 32'h0, 32'h00AD00EF, 1};
    tv[9]  = '{32'h3000_0410, 1'b0, 4'hF, 32'h0, 32'h00AD00EF, 1};
    tv[10] = '{32'h3000_0808, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1};
    tv[11] = '{32'h3000_0808, 1'b0, 4'hF, 32'h0, 32'h0FF, 1};
    tv[12] = '{32'h3000_080C, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1};
    tv[13] = '{32'h3000_080C, 1'b0, 4'hF, 32'h0, 32'h1FF, 1};
    tv[14] = '{32'h3000_080C, 1'b1, 4'h2, 32'h0, 32'h0, 1};
    tv[15] = '{32'h3000_080C, 1'b0, 4'hF, 32'h0, 32'h0FF, 1};
    tv[16] = '{32'h3000_0800, 1'b0, 4'hF, 32'h0, 32'h0, 1};
    tv[17] = '{32'h3000_1000, 1'b0, 4'hF, 32'h0, 32'h0, 0};
    tv[18] = '{32'h3000_2804, 1'b0, 4'hF, 32'h0, 32'h0, 3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_vld", 32'(bus0.stream_valid_o), 32'd0);
    chk("rst_sdat", bus0.stream_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      wb(tv[i].adr, tv[i].we, tv[i].sel, tv[i].dat, rd, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      if (!tv[i].we) chk($sformatf("v%0d_dat", i), rd, tv[i].exp);
      if (i == 0) chk("v0_vld", 32'(bus0.stream_valid_o), 32'd0);
    end

    // Burst of four from words 2..5 with the array always ready.
    for (int i = 0; i < 8; i++)
      wr(32'h3000_0000 + 32'(4 * i), 32'h100 + 32'(i));
    rdy = 1'b1;
    base = q0.size();
    wr(32'h3000_0808, 32'd2);
    wr(32'h3000_080C, 32'd4);
    wr(32'h3000_0800, 32'd1);
    wait_beats(base, 4);
    chk_beats("b1", base, 4, 32'h102);
    rd_chk("b1_status", 32'h3000_0804, 32'h2);

    // ADDR_W=4 window wrapping 14,15,0 under a 1-in-3 ready.
    rdy = 1'b0;
    wr(32'h3000_3038, 32'hA0E);
    wr(32'h3000_303C, 32'hA0F);
    wr(32'h3000_3000, 32'hA00);
    wr(32'h3000_3808, 32'd14);
    wr(32'h3000_380C, 32'd3);
    wr(32'h3000_3800, 32'd1);
    ps = 1'b0; pl = 1'b0; pd = 32'h0; got = 0;
    for (int i = 0; i < 3; i++) b4[i] = 33'h0;
    for (int c = 0; c < 90 && got < 3; c++) begin
      @(posedge clk); #1;
      rdy = (c % 3 == 2);
      @(negedge clk);
      if (ps) begin
        chk("hold_vld", 32'(bus4.stream_valid_o), 32'd1);
        chk("hold_dat", bus4.stream_data_o, pd);
        chk("hold_last", 32'(bus4.stream_last_o), 32'(pl));
      end
      if (bus4.stream_valid_o && rdy) begin
        b4[got] = {bus4.stream_last_o, bus4.stream_data_o};
        got++;
      end
      ps = bus4.stream_valid_o && !rdy;
      pd = bus4.stream_data_o;
      pl = bus4.stream_last_o;
    end
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("b4_count", 32'(got), 32'd3);
    chk("b4_w14", b4[0][31:0], 32'hA0E);
    chk("b4_w15", b4[1][31:0], 32'hA0F);
    chk("b4_w0", b4[2][31:0], 32'hA00);
    chk("b4_last", {29'd0, b4[2][32], b4[1][32], b4[0][32]}, 32'h4);

    // Wishbone RAM reads interleaved with an 8-word burst.
    for (int i = 0; i < 8; i++)
      wr(32'h3000_0080 + 32'(4 * i), 32'h200 + 32'(i));
    wr(32'h3000_0808, 32'h20);
    wr(32'h3000_080C, 32'd8);
    rdy = 1'b1;
    base = q0.size();
    wr(32'h3000_0800, 32'd1);
    for (int i = 0; i < 12; i++)
      rd_chk($sformatf("bg_rd%0d", i), 32'h3000_0010, 32'h104);
    wait_beats(base, 8);
    chk_beats("b3", base, 8, 32'h200);

    // Reset while a word is held aborts the burst at once.
    rdy = 1'b0;
    wr(32'h3000_0800, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_vld", 32'(bus0.stream_valid_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_vld", 32'(bus0.stream_valid_o), 32'd0);
    chk("mid_rst_last", 32'(bus0.stream_last_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("rst_status", 32'h3000_0804, 32'h0);
    rd_chk("rst_src", 32'h3000_0808, 32'h0);
    rd_chk("rst_len", 32'h3000_080C, 32'h0);

    // LEN=0 start only raises done.
    rdy = 1'b1;
    base = q0.size();
    wr(32'h3000_0800, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("len0_beats", 32'(q0.size() - base), 32'd0);
    rd_chk("len0_status", 32'h3000_0804, 32'h2);

    // A second start during a burst is dropped.
    rdy = 1'b0;
    wr(32'h3000_0808, 32'h20);
    wr(32'h3000_080C, 32'd2);
    wr(32'h3000_0800, 32'd1);
    rd_chk("busy_status", 32'h3000_0804, 32'h1);
    wr(32'h3000_0808, 32'h24);
    wr(32'h3000_080C, 32'd5);
    wr(32'h3000_0800, 32'd1);
    rd_chk("busy_status2", 32'h3000_0804, 32'h1);
    base = q0.size();
    rdy = 1'b1;
    wait_beats(base, 2);
    chk_beats("b5", base, 2, 32'h200);
    rd_chk("b5_status", 32'h3000_0804, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/edu_tpu_wb_mem.md
Name: edu_tpu_wb_mem

Overview:
Parametrised Caravel Wishbone slave for the TPU.
- Holds a single-port operand RAM of 2^ADDR_W 32-bit words, with configurable ACK wait states.
- Adds a DMA-style stream engine that reads a programmed RAM window and pushes words to the systolic array over a valid/ready port.
- Sits between the Caravel management bus and the TPU datapath.

Parameters:
- BASE_ADDRESS, 20'h3000_0: matched against caravel_wb_adr_i[31:12]; defines a 4 KB window.
- ADDR_W, 8: RAM word-address width; depth = 2^ADDR_W; legal range 4..9.
- WAIT_STATES, 0: extra cycles inserted before ACK; legal range 0..3.

Ports:
- caravel_wb_clk_i  in  1  system clock
- caravel_wb_rst_i  in  1  synchronous, active-high reset
- caravel_wb_stb_i  in  1  strobe
- caravel_wb_cyc_i  in  1  bus cycle
- caravel_wb_we_i  in  1  write enable
- caravel_wb_sel_i  in  4  byte lane select
- caravel_wb_dat_i  in  32  write data
- caravel_wb_adr_i  in  32  byte address
- caravel_wb_ack_o  out  1  acknowledge
- caravel_wb_dat_o  out  32  read data
- stream_data_o  out  32  operand word to the array
- stream_valid_o  out  1  stream word valid
- stream_ready_i  in  1  array accepts word
- stream_last_o  out  1  final word of burst, qualified by valid

Behaviour:
Clock and reset:
- One clock: caravel_wb_clk_i. Reset: caravel_wb_rst_i, synchronous and active-high.
- Reset clears ack, dat_o, stream_valid_o, stream_last_o, stream_data_o, SRC, LEN, busy, done, FSM=IDLE. RAM contents are not reset.

Address decode:
- hit = cyc & stb & (adr[31:12]==BASE_ADDRESS).
- adr[11]=0: RAM access; word index = adr[ADDR_W+1:2]; upper offset bits ignored (aliasing).
- adr[11]=1: register access, selected by adr[3:2].
  - 0x800 CTRL (W): bit0=1 starts a burst. Reads return 0.
  - 0x804 STATUS (R): bit0 busy, bit1 done.
  - 0x808 SRC (RW): bits [ADDR_W-1:0].
  - 0x80C LEN (RW): bits [ADDR_W:0], word count.
- No hit: no ACK, no state change. Other slaves answer.

Wishbone timing:
- For a hit first sampled in cycle N, ACK is a 1-cycle pulse in cycle N+1+WAIT_STATES.
- Read data is valid only in the ACK cycle; caravel_wb_dat_o = 0 otherwise.
- Writes commit at the ACK edge, per-byte on sel. sel=0 means no change, still ACKed.
- Register writes honour sel, byte-wise.
- If cyc or stb drops before ACK: access abandoned, no write, no ACK.
- The next access may begin the cycle after ACK. Back-to-back transactions are supported.

RAM arbitration:
- The RAM has a synchronous read with 1-cycle latency.
- A Wishbone RAM access has priority and takes the port in its first cycle.
- The stream engine issues a read only in cycles with no Wishbone RAM hit.
- Register accesses never block the stream.

Stream FSM:
- IDLE:
  - CTRL write with bit0=1 and LEN>0: latch ptr=SRC, rem=LEN, busy=1, done=0 → FETCH.
  - Start with LEN=0: done=1, busy stays 0, no beat.
  - Start while busy: ignored.
- FETCH: issue RAM read at ptr when the port is free, else wait. → LOAD.
- LOAD: capture RAM data into stream_data_o; valid=1; last=(rem==1) → HOLD.
- HOLD:
  - Data, valid and last are held stable until stream_ready_i.
  - On valid & ready: valid=0, last=0, ptr=ptr+1 mod 2^ADDR_W (wraps), rem=rem-1.
  - If rem was 1: busy=0, done=1 → IDLE. Else → FETCH.
- Best-case throughput: 1 word per 3 cycles.
- done is sticky until the next accepted start.
- A reset mid-burst aborts immediately.
- A Wishbone write to a word already fetched does not alter the held output.

Test Plan:
- Reset, then read STATUS at 0x3000_0804, WAIT_STATES=0 → ACK exactly 1 cycle after stb; dat=0; stream_valid_o=0.
- Write 0xDEADBEEF to 0x3000_0010 with sel=4'b0101, then read → 0x00AD00EF (RAM preloaded with 0). Repeat with WAIT_STATES=2 → ACK 3 cycles after stb.
- Fill words 0..7 with 0x100+i; SRC=2, LEN=4, CTRL=1, ready tied 1 → beats 0x102..0x105 in order; last only on 0x105; STATUS then = 0x2.
- ADDR_W=4: SRC=14, LEN=3; toggle ready 1 cycle in 3 → words 14,15,0; data held stable during each stall.
- Continuous Wishbone RAM reads during a burst → every Wishbone access ACKs on time; stream stalls but all words are delivered correct.
- Assert reset mid-burst → next cycle valid=0, STATUS=0. LEN=0 start → done=1 with no beat. Start while busy → ignored. Access at 0x3000_1000 → no ACK.
